fetch_sequencer: RTL and testbench

//  Instruction-fetch controller directly downstream of the 8-bit program counter.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_ir_latch.sv | 42 ++++
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// The jump test takes the prefix as an argument so a re-parameterised sequencer stays consistent.
package fetch_pkg;

  localparam int         DEF_WIDTH      = 8;
  localparam logic [1:0] DEF_JMP_PREFIX = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_ISSUE = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

  function automatic logic is_jump_op(input logic [1:0] top2, input logic [1:0] prefix);
    return (top2 == prefix);
  endfunction

endpackage

// File: rtl/fetch_ir_latch.sv
// Instruction register: captures the opcode and operand bytes and holds them for the execute stage.
// Capturing an opcode clears the operand so a 1-byte instruction always presents operand 0.
module fetch_ir_latch
  import fetch_pkg::*;
#(
  parameter int         WIDTH      = DEF_WIDTH,
  parameter logic [1:0] JMP_PREFIX = DEF_JMP_PREFIX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_opcode_i,
  input  logic             cap_operand_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [WIDTH-1:0] opcode_o,
  output logic [WIDTH-1:0] operand_o,
  output logic             is_jump_o
);

  logic [WIDTH-1:0] opcode_q;
  logic [WIDTH-1:0] operand_q;
  logic             is_jump_q;

  // Opcode/operand capture; contents are held between captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      operand_q <= '0;
      is_jump_q <= 1'b0;
    end else if (cap_opcode_i) begin
      opcode_q  <= rdata_i;
      operand_q <= '0;
      is_jump_q <= is_jump_op(rdata_i[WIDTH-1 -: 2], JMP_PREFIX);
    end else if (cap_operand_i) begin
      operand_q <= rdata_i;
    end
  end

  assign opcode_o  = opcode_q;
  assign operand_o = operand_q;
  assign is_jump_o = is_jump_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller between the program counter and the execute stage.
// Reads the PC off the shared bus, fetches 1-byte ops or 2-byte jumps, and steers the PC.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int         WIDTH      = DEF_WIDTH,
  parameter logic [1:0] JMP_PREFIX = DEF_JMP_PREFIX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_addr,
  input  logic [WIDTH-1:0] pc_bus,
  output logic             pc_out_en,
  output logic             pc_en,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_load_val,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_opcode,
  output logic [WIDTH-1:0] instr_operand,
  output logic             instr_is_jump
);

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic             cap_opcode;
  logic             cap_operand;

  fetch_ir_latch #(
    .WIDTH      (WIDTH),
    .JMP_PREFIX (JMP_PREFIX)
  ) u_ir (
    .clk           (clk),
    .rst_n         (rst_n),
    .cap_opcode_i  (cap_opcode),
    .cap_operand_i (cap_operand),
    .rdata_i       (mem_rdata),
    .opcode_o      (instr_opcode),
    .operand_o     (instr_operand),
    .is_jump_o     (instr_is_jump)
  );

  assign mem_addr    = mem_addr_q;
  assign instr_valid = (state_q == S_ISSUE);

  // State, byte phase and fetch address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next state and PC/memory strobes; flush overrides everything in any state.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    mem_addr_d  = mem_addr_q;
    pc_out_en   = 1'b0;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    mem_req     = 1'b0;
    cap_opcode  = 1'b0;
    cap_operand = 1'b0;
    if (flush) begin
      pc_load     = 1'b1;
      pc_load_val = flush_addr;
      phase_d     = 1'b0;
      // A response that lands in the flush cycle is already consumed, so no drain is needed.
      case (state_q)
        S_IDLE:  state_d = start ? S_ADDR : S_IDLE;
        S_REQ:   state_d = mem_gnt ? S_DRAIN : S_ADDR;
        S_WAIT:  state_d = mem_rvalid ? S_ADDR : S_DRAIN;
        S_DRAIN: state_d = mem_rvalid ? S_ADDR : S_DRAIN;
        default: state_d = S_ADDR;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ADDR;
            phase_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          pc_out_en  = 1'b1;
          pc_en      = 1'b1;
          mem_addr_d = pc_bus;
          state_d    = S_REQ;
        end
        S_REQ: begin
          mem_req = 1'b1;
          state_d = mem_gnt ? S_WAIT : S_REQ;
        end
        S_WAIT: begin
          if (mem_rvalid && !phase_q) begin
            cap_opcode = 1'b1;
            if (is_jump_op(mem_rdata[WIDTH-1 -: 2], JMP_PREFIX)) begin
              state_d = S_ADDR;
              phase_d = 1'b1;
            end else begin
              state_d = S_ISSUE;
            end
          end else if (mem_rvalid) begin
            cap_operand = 1'b1;
            state_d     = S_ISSUE;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            pc_load     = instr_is_jump;
            pc_load_val = instr_is_jump ? instr_operand : '0;
            state_d     = S_ADDR;
            phase_d     = 1'b0;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_DRAIN: state_d = mem_rvalid ? S_ADDR : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: external PC and memory models, a program-walking
// reference that predicts the instruction stream, and a monitor that checks every handshake.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] opd;
    logic       j;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] flush_addr = 8'h00;
  logic [7:0] pc_bus;
  logic       pc_out_en, pc_en, pc_load;
  logic [7:0] pc_load_val;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_gnt = 1'b0;
  logic       mem_rvalid = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_opcode, instr_operand;
  logic       instr_is_jump;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int handshakes = 0;

  logic [7:0] mem [256];
  logic [7:0] pc_val = 8'h00;
  logic [7:0] junk = 8'h00;
  instr_t     exp_q [$];
  logic [7:0] walk_pc = 8'h00;
  logic [7:0] pend [$];
  int  gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;
  int  gnt_dly = 0, gnt_cnt = 0, rv_dly = 0, rv_cnt = 0;
  bit  spur_rv = 1'b0;

  // monitor history
  logic        pv = 1'b0, pr = 1'b0, pf = 1'b0, preq = 1'b0, pg = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [16:0] ppay = 17'h0;
  instr_t      got_e, exp_e;
  // memory-model samples
  logic        s_req = 1'b0, s_gnt = 1'b0, s_rv = 1'b0;
  logic [7:0]  s_addr = 8'h00;
  // PC-model samples
  logic        s_en = 1'b0, s_ld = 1'b0;
  logic [7:0]  s_lv = 8'h00;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .pc_bus        (pc_bus),
    .pc_out_en     (pc_out_en),
    .pc_en         (pc_en),
    .pc_load       (pc_load),
    .pc_load_val   (pc_load_val),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_is_jump (instr_is_jump)
  );

  always #5 clk = ~clk;

  // The bus carries garbage whenever the PC driver is disabled.
  assign pc_bus = pc_out_en ? pc_val : junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the program from walk_pc following the ISA rules.
  task automatic push_next();
    instr_t e;
    e.op = mem[walk_pc];
    e.j  = (e.op[7:6] == 2'b11);
    if (e.j) begin
      e.opd   = mem[8'(walk_pc + 8'd1)];
      walk_pc = e.opd;
    end else begin
      e.opd   = 8'h00;
      walk_pc = 8'(walk_pc + 8'd1);
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // External program counter.
  initial forever begin
    @(negedge clk);
    s_en = pc_en; s_ld = pc_load; s_lv = pc_load_val;
    @(posedge clk);
    #1;
    if (s_ld) pc_val = s_lv;
    else if (s_en) pc_val = 8'(pc_val + 8'd1);
    junk = 8'($urandom);
  end

  // Memory: grant after gnt_dly cycles of request, respond rv_dly cycles after the grant.
  initial forever begin
    @(negedge clk);
    s_req = mem_req; s_gnt = mem_gnt; s_rv = mem_rvalid; s_addr = mem_addr;
    @(posedge clk);
    if (s_rv && pend.size() > 0) void'(pend.pop_front());
    if (s_req && s_gnt) pend.push_back(s_addr);
    #2;
    if (mem_req && gnt_cnt >= gnt_dly) begin
      mem_gnt = 1'b1; gnt_cnt = 0; gnt_dly = $urandom_range(gnt_max, gnt_min);
    end else if (mem_req) begin
      mem_gnt = 1'b0; gnt_cnt++;
    end else begin
      mem_gnt = 1'b0;
    end
    if (pend.size() > 0 && rv_cnt >= rv_dly) begin
      mem_rvalid = 1'b1; mem_rdata = mem[pend[0]]; rv_cnt = 0; rv_dly = $urandom_range(rv_max, rv_min);
    end else if (pend.size() > 0) begin
      mem_rvalid = 1'b0; mem_rdata = junk; rv_cnt++;
    end else if (spur_rv) begin
      mem_rvalid = 1'b1; mem_rdata = 8'hC3;
    end else begin
      mem_rvalid = 1'b0; mem_rdata = junk;
    end
  end

  // Keep the expected stream topped up after any redirect.
  initial forever begin
    @(posedge clk);
    #3;
    while (exp_q.size() < 8) push_next();
  end

  // Monitor: scoreboard pops on handshakes plus protocol checks.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pf = 1'b0; preq = 1'b0; pg = 1'b0;
    end else begin
      if (pc_en) check("pc_en_load_excl", 32'(pc_load), 32'd0);
      if (pc_en || pc_out_en) check("pc_en_with_out_en", 32'(pc_en), 32'(pc_out_en));
      if (flush) begin
        check("flush_ctrl", 32'({pc_load, pc_load_val, pc_en, pc_out_en, mem_req}),
              32'({1'b1, flush_addr, 3'b000}));
      end else if (instr_valid && instr_ready) begin
        handshakes++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_e = exp_q.pop_front();
          got_e = '{op: instr_opcode, opd: instr_operand, j: instr_is_jump};
          check("instr", 32'(got_e), 32'(exp_e));
          check("jump_load", 32'({pc_load, pc_load_val}), exp_e.j ? 32'({1'b1, exp_e.opd}) : 32'd0);
        end
      end
      if (pf) check("valid_after_flush", 32'(instr_valid), 32'd0);
      else if (pv && !pr)
        check("issue_hold", 32'({instr_valid, instr_opcode, instr_operand, instr_is_jump}), 32'({1'b1, ppay}));
      if (preq && !pg && !pf && !flush)
        check("req_hold", 32'({mem_req, mem_addr}), 32'({1'b1, paddr}));
      pv = instr_valid; pr = instr_ready; pf = flush; preq = mem_req; pg = mem_gnt; paddr = mem_addr;
      ppay = {instr_opcode, instr_operand, instr_is_jump};
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 32'({pc_out_en, pc_en, pc_load, mem_req, instr_valid, instr_is_jump}), 32'd0);
    check({name, "_data"}, {pc_load_val, mem_addr, instr_opcode, instr_operand}, 32'd0);
  endtask

  task automatic set_timing(input int gmin, input int gmax, input int rmin, input int rmax);
    gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
    gnt_dly = $urandom_range(gmax, gmin); gnt_cnt = 0;
    rv_dly = $urandom_range(rmax, rmin); rv_cnt = 0;
  endtask

  task automatic do_reset(input logic [7:0] pc0);
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pc_val = pc0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    walk_pc = pc_val;
    exp_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_flush(input logic [7:0] a);
    flush = 1'b1; flush_addr = a;
    exp_q.delete();
    walk_pc = a;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Wait for the first ADDR cycle, then for instr_valid; report latency and pc_en pulses.
  task automatic fetch_latency(output int lat, output int npcen);
    bit seen;
    int t0;
    lat = -1; npcen = 0; seen = 1'b0; t0 = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pc_out_en) begin seen = 1'b1; t0 = cyc; npcen = int'(pc_en); end
    end
    check("addr_seen", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) begin seen = 1'b1; lat = cyc - t0; end
      else npcen += int'(pc_en);
    end
    check("valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check("req_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int lat, npcen, nvalid;
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // 1: single-byte instruction, zero-wait memory
    set_timing(0, 0, 0, 0);
    mem[8'h10] = 8'h05;
    instr_ready = 1'b1;
    do_reset(8'h10);
    pulse_start();
    fetch_latency(lat, npcen);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_pc_en_pulses", 32'(npcen), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // 2: jump C3 40 -> target loaded at handshake, next fetch at 0x40
    mem[8'h20] = 8'hC3; mem[8'h21] = 8'h40; mem[8'h40] = 8'h07;
    do_reset(8'h20);
    pulse_start();
    fetch_latency(lat, npcen);
    check("t2_latency", 32'(lat), 32'd6);
    check("t2_pc_en_pulses", 32'(npcen), 32'd2);
    check("t2_jump_load", 32'({pc_load, pc_load_val}), 32'h140);
    wait_req(seen);
    check("t2_next_addr", 32'(mem_addr), 32'h40);
    repeat (6) @(posedge clk);
    #1;

    // 3: grant delayed 3 cycles, execute stalls 4 cycles
    mem[8'h30] = 8'h12;
    set_timing(3, 3, 0, 0);
    instr_ready = 1'b0;
    do_reset(8'h30);
    pulse_start();
    fetch_latency(lat, npcen);
    check("t3_latency", 32'(lat), 32'd6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      npcen += int'(pc_en);
    end
    check("t3_pc_en_pulses", 32'(npcen), 32'd1);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // 4: flush while waiting on memory; the pending byte is dropped
    mem[8'h50] = 8'h21; mem[8'h80] = 8'h33;
    set_timing(0, 0, 3, 3);
    do_reset(8'h50);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_gnt) seen = 1'b1;
    end
    check("t4_grant_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    do_flush(8'h80);
    nvalid = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
      nvalid += int'(instr_valid);
    end
    check("t4_req_seen", 32'(seen), 32'd1);
    check("t4_no_valid", 32'(nvalid), 32'd0);
    check("t4_next_addr", 32'(mem_addr), 32'h80);
    repeat (30) @(posedge clk);
    #1;

    // 5: flush on the same cycle as a jump handshake
    mem[8'h60] = 8'h09;
    set_timing(0, 0, 0, 0);
    instr_ready = 1'b0;
    do_reset(8'h20);
    pulse_start();
    fetch_latency(lat, npcen);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    do_flush(8'h60);
    @(negedge clk);
    check("t5_pc_after_flush", 32'(pc_val), 32'h60);
    wait_req(seen);
    check("t5_next_addr", 32'(mem_addr), 32'h60);
    repeat (10) @(posedge clk);
    #1;

    // 6: asynchronous reset mid-request, then a stray rvalid in IDLE, then restart
    mem[8'h70] = 8'h44;
    set_timing(20, 20, 0, 0);
    do_reset(8'h70);
    pulse_start();
    wait_req(seen);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async_reset");
    @(posedge clk);
    #1;
    set_timing(0, 0, 0, 0);
    pc_val = 8'h70;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    spur_rv = 1'b1;
    @(posedge clk);
    #1;
    spur_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_ignore_rv", 32'({pc_out_en, mem_req, instr_valid, instr_opcode}), 32'd0);
    end
    @(posedge clk);
    #1;
    pulse_start();
    fetch_latency(lat, npcen);
    check("t6_restart_latency", 32'(lat), 32'd3);
    repeat (10) @(posedge clk);
    #1;

    // Random program, random memory timing, random back-pressure and flushes
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    set_timing(0, 3, 0, 3);
    do_reset(8'($urandom));
    handshakes = 0;
    pulse_start();
    for (int c = 0; c < 1500; c++) begin
      instr_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(30, 0) == 0) begin
        do_flush(8'($urandom));
      end else begin
        @(posedge clk);
        #1;
      end
    end
    instr_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rand_progress", 32'(handshakes > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
